// File: rtl/vreg_i2c_target.sv
// vreg_i2c_target: two-wire bus target for the voltage regulator.
// Decodes START/STOP, the address byte, a register pointer and data bytes.
// It ACKs matching traffic and holds the CONTROL, VOUT_LEVEL and STATUS
// registers. It drives the applied output level and returns status on reads.
//
// Optional build macro: VREG_SLEW_EN. When it is defined, the applied level
// ramps one step toward the target every SLEW_CYCLES clocks. When it is not
// defined, the applied level follows the target one cycle after the write.
//
// Ports:
//   clk, rst_n    system clock (>= 8x SCL), asynchronous active-low reset
//   scl, sda_in   bus clock and sampled bus data from the initiator
//   sda_oe        1 = pull SDA low (open-drain), 0 = release
//   fault_in      regulator fault level; latched into STATUS[2]
//   vout_level    applied voltage level
//   vout_enable   CONTROL[0]
//   vout_update   one-cycle pulse after a VOUT_LEVEL write
//   power_good    enabled, applied == target, and no latched fault
//   bus_busy      high from START to STOP
//
// Bus handshake: a byte is 8 bits that are sampled on detected SCL rising
// edges, MSB first, followed by one ACK bit. The target changes sda_oe only in
// the cycle after a detected SCL falling edge. For writes, it pulls SDA low for
// the whole ACK clock. For reads, it releases SDA for 1 bits and samples the
// initiator's ACK/NACK on the 9th rising edge.
module vreg_i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h40,
  parameter int         SYNC_STAGES = 2,
  parameter int         SLEW_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       fault_in,
  output logic [2:0] vout_level,
  output logic       vout_enable,
  output logic       vout_update,
  output logic       power_good,
  output logic       bus_busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, IGNORE
  } state_e;

  // Synchronizers reset to 1 (the idle bus level) so that leaving reset on an
  // idle bus produces no phantom edges.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;      // bits seen in the current byte, 0..8
  logic [7:0]  shift_q, shift_d;
  logic [6:0]  tx_q, tx_d;        // read bits still to be sent after the current one
  logic        rw_q, rw_d, ack_q, ack_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic        en_q, en_d, fault_q, fault_d, upd_q, upd_d;
  logic [2:0]  target_q, target_d, level_q, level_d;
  logic        wr_en, fault_clr;
  logic [7:0]  byte_in, rd_data;

  assign byte_in = {shift_q[6:0], sda_s};

`ifdef VREG_SLEW_EN
  localparam int SW = (SLEW_CYCLES > 1) ? $clog2(SLEW_CYCLES) : 1;
  localparam logic [SW-1:0] SLEW_LAST = SW'(SLEW_CYCLES - 1);
  logic [SW-1:0] slew_cnt_q, slew_cnt_d;
`endif

  always_comb begin
    rd_data = 8'h00;
    case (ptr_q)
      8'h00:   rd_data = {7'b0, en_q};
      8'h01:   rd_data = {5'b0, target_q};
      8'h02:   rd_data = {5'b0, fault_q, en_q, power_good};
      default: rd_data = 8'h00;
    endcase
  end

  // Bus state machine.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    rw_d     = rw_q;
    ack_d    = ack_q;
    ptr_d    = ptr_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    wr_en    = 1'b0;
    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (state_q == PTR) ptr_d = byte_in;
              if (state_q == WDATA) begin
                wr_en = 1'b1;
                ptr_d = ptr_q + 8'd1;
              end
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            // The falling edge that ends the 8th bit opens the ACK clock.
            cnt_d    = 4'd0;
            sda_oe_d = 1'b1;
            case (state_q)
              ADDR: begin
                if (shift_q[7:1] == DEV_ADDR) begin
                  state_d = ADDR_ACK;
                  rw_d    = shift_q[0];
                end else begin
                  state_d  = IGNORE;
                  sda_oe_d = 1'b0;
                end
              end
              PTR:     state_d = PTR_ACK;
              default: state_d = WACK;
            endcase
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              state_d  = RDATA;
              tx_d     = rd_data[6:0];
              sda_oe_d = ~rd_data[7];
            end else begin
              state_d  = PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        PTR_ACK, WACK: begin
          if (scl_fall) begin
            state_d  = WDATA;
            sda_oe_d = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) ptr_d = ptr_q + 8'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            state_d  = RACK;
          end else if (scl_fall && cnt_q != 4'd0) begin
            tx_d     = {tx_q[5:0], 1'b0};
            sda_oe_d = ~tx_q[6];
          end
        end
        RACK: begin
          if (scl_rise) begin
            ack_d = ~sda_s;
          end else if (scl_fall) begin
            if (ack_q) begin
              state_d  = RDATA;
              tx_d     = rd_data[6:0];
              sda_oe_d = ~rd_data[7];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Register file and the applied output level.
  always_comb begin
    en_d      = en_q;
    target_d  = target_q;
    upd_d     = 1'b0;
    fault_clr = 1'b0;
    if (wr_en) begin
      case (ptr_q)
        8'h00: en_d = byte_in[0];
        8'h01: begin
          target_d = byte_in[2:0];
          upd_d    = 1'b1;
        end
        8'h02:   fault_clr = byte_in[2];
        default: ;
      endcase
    end
    // If a new fault and a clear happen together, the fault wins.
    fault_d = fault_in | (fault_q & ~fault_clr);
`ifdef VREG_SLEW_EN
    level_d    = level_q;
    slew_cnt_d = slew_cnt_q;
    if (upd_d) begin
      slew_cnt_d = '0;
    end else if (level_q != target_q) begin
      if (slew_cnt_q == SLEW_LAST) begin
        slew_cnt_d = '0;
        level_d    = (level_q < target_q) ? level_q + 3'd1 : level_q - 3'd1;
      end else begin
        slew_cnt_d = slew_cnt_q + 1'b1;
      end
    end else begin
      slew_cnt_d = '0;
    end
`else
    level_d = target_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      tx_q       <= 7'h00;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      ptr_q      <= 8'h00;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      fault_q    <= 1'b0;
      upd_q      <= 1'b0;
      target_q   <= 3'd4;
      level_q    <= 3'd4;
`ifdef VREG_SLEW_EN
      slew_cnt_q <= '0;
`endif
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      en_q       <= en_d;
      fault_q    <= fault_d;
      upd_q      <= upd_d;
      target_q   <= target_d;
      level_q    <= level_d;
`ifdef VREG_SLEW_EN
      slew_cnt_q <= slew_cnt_d;
`endif
    end
  end

  assign sda_oe      = sda_oe_q;
  assign vout_level  = level_q;
  assign vout_enable = en_q;
  assign vout_update = upd_q;
  assign power_good  = en_q & (level_q == target_q) & ~fault_q;
  assign bus_busy    = busy_q;

endmodule
